// File: rtl/hour_bcd_converter_pkg.sv
// Shared widths for the hour-to-BCD converter and its consumers.
package hour_bcd_converter_pkg;

  localparam int unsigned BIN_W = 6;
  localparam int unsigned BCD_W = 8;

endpackage

// File: rtl/hour_bcd_converter_add3.sv
// Double-dabble correction cell: adds 3 to a BCD nibble that is 5 or more.
module bcd_add3 (
  input  logic [3:0] in_i,
  output logic [3:0] out_o
);

  always_comb begin
    out_o = in_i;
    if (in_i >= 4'd5) begin
      out_o = in_i + 4'd3;
    end
  end

endmodule

// File: rtl/hour_bcd_converter.sv
// Registered 6-bit binary to two-digit packed BCD converter (double-dabble array).
module hour_bcd_converter
  import hour_bcd_converter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [BIN_W-1:0] bin,
  output logic [BCD_W-1:0] bcd
);

  logic [3:0]       units_c1, units_c2, units_c3;
  logic [3:0]       tens_c1;
  logic [BCD_W-1:0] bcd_d, bcd_q;
  logic             unused_tens_msb;

  // Units column: one correction before each of the last three shifts.
  bcd_add3 u_units_c1 (
    .in_i  ({1'b0, bin[5:3]}),
    .out_o (units_c1)
  );

  bcd_add3 u_units_c2 (
    .in_i  ({units_c1[2:0], bin[2]}),
    .out_o (units_c2)
  );

  bcd_add3 u_units_c3 (
    .in_i  ({units_c2[2:0], bin[1]}),
    .out_o (units_c3)
  );

  // Tens column before the final shift; its value never exceeds 3, so bit 3 is always 0.
  bcd_add3 u_tens_c1 (
    .in_i  ({2'b00, units_c1[3], units_c2[3]}),
    .out_o (tens_c1)
  );

  assign unused_tens_msb = tens_c1[3];

  always_comb begin
    bcd_d = {tens_c1[2:0], units_c3[3], units_c3[2:0], bin[0]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcd_q <= '0;
    end else begin
      bcd_q <= bcd_d;
    end
  end

  assign bcd = bcd_q;

endmodule

// File: tb/tb_hour_bcd_converter.sv
// Self-checking bench for hour_bcd_converter: vector table, sweep, reset and random checks.
module tb_hour_bcd_converter;

  logic       clk;
  logic       reset;
  logic [5:0] bin;
  logic [7:0] bcd;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic [5:0] bin;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [9];

  hour_bcd_converter dut (
    .clk   (clk),
    .reset (reset),
    .bin   (bin),
    .bcd   (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal digits by plain arithmetic.
  function automatic logic [7:0] ref_bcd(input int v);
    int t;
    int u;
    t = v / 10;
    u = v % 10;
    return {t[3:0], u[3:0]};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] prev;
    int         v;

    vecs[0] = '{6'd9,  8'h09};
    vecs[1] = '{6'd10, 8'h10};
    vecs[2] = '{6'd19, 8'h19};
    vecs[3] = '{6'd20, 8'h20};
    vecs[4] = '{6'd24, 8'h24};
    vecs[5] = '{6'd0,  8'h00};
    vecs[6] = '{6'd23, 8'h23};
    vecs[7] = '{6'd63, 8'h63};
    vecs[8] = '{6'd59, 8'h59};

    // Reset held while clocking.
    reset = 1'b0;
    bin   = 6'd37;
    #2;
    check("reset_initial", bcd, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_held", bcd, 8'h00);
    end

    // Latency after release.
    reset = 1'b1;
    bin   = 6'd14;
    #2;
    check("latency_before_edge", bcd, 8'h00);
    step();
    check("latency_14", bcd, 8'h14);
    bin = 6'd5;
    #2;
    check("latency_hold_14", bcd, 8'h14);
    step();
    check("latency_05", bcd, 8'h05);

    // Digit boundary table.
    for (int i = 0; i < 9; i++) begin
      bin = vecs[i].bin;
      step();
      check($sformatf("table_bin%0d", vecs[i].bin), bcd, vecs[i].exp);
    end

    // Exhaustive sweep with an asynchronous reset in the middle.
    for (int i = 0; i < 64; i++) begin
      bin = i[5:0];
      step();
      check($sformatf("sweep_bin%0d", i), bcd, ref_bcd(i));
      total_cnt++;
      if (bcd[7:4] <= 4'd9 && bcd[3:0] <= 4'd9) begin
        pass_cnt++;
      end else begin
        $display("FAIL sweep_nibble_legal bin%0d: got %h, expected digits <= 9", i, bcd);
      end
      if (i == 30) begin
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_drop", bcd, 8'h00);
        step();
        check("async_reset_held_edge", bcd, 8'h00);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset_release_no_edge", bcd, 8'h00);
        step();
        check("async_reset_reload", bcd, 8'h30);
      end
    end

    // Back-to-back extremes.
    prev = bcd;
    for (int i = 0; i < 8; i++) begin
      bin = (i % 2 == 0) ? 6'd0 : 6'd63;
      #2;
      check("alt_lag", bcd, prev);
      step();
      prev = (i % 2 == 0) ? 8'h00 : 8'h63;
      check("alt_value", bcd, prev);
    end

    // Random stimulus against the reference.
    for (int i = 0; i < 200; i++) begin
      v   = int'($urandom_range(63, 0));
      bin = v[5:0];
      step();
      check($sformatf("rand_bin%0d", v), bcd, ref_bcd(v));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
